// File: rtl/cnn_pkg.sv
// Shared widths and beat types for the CNN activation stages.
package cnn_pkg;

  localparam int unsigned PIX_W = 16;
  localparam int unsigned ACT_W = 8;

  typedef logic signed [PIX_W-1:0] pix_t;
  typedef logic [ACT_W-1:0]        act_t;

  typedef struct packed {
    act_t data;
    logic last;
  } act_beat_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head; the head holds its value
// while empty, and a push into an empty slot at the head is forwarded directly.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;
  logic             r_valid;
  logic             r_full;
  logic             r_empty;

  logic             w_do_push;
  logic             w_do_pop;
  logic [AW-1:0]    w_rd_next;
  logic [CW-1:0]    w_count_next;
  logic [WIDTH-1:0] w_head_next;

  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign w_do_pop     = i_pop && !r_empty;
  assign w_do_push    = i_push && (!r_full || w_do_pop);
  assign w_rd_next    = w_do_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
  assign w_count_next = r_count + CW'(w_do_push) - CW'(w_do_pop);

  always_comb begin
    w_head_next = r_head;
    if (w_count_next != '0) begin
      if (w_do_push && (r_wr_ptr == w_rd_next)) begin
        w_head_next = i_data;
      end else begin
        w_head_next = r_mem[w_rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_head   <= w_head_next;
      r_valid  <= (w_count_next != '0);
      r_full   <= (w_count_next == CW'(DEPTH));
      r_empty  <= (w_count_next == '0);
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_head;
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/relu_requantizer.sv
// ReLU, round-and-shift, saturate to 8 bits, tag frame ends and buffer results
// for a valid/ready consumer; sticky overflow when a result cannot be stored.
module relu_requantizer
  import cnn_pkg::*;
#(
  parameter int unsigned SHIFT        = 4,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned FRAME_PIXELS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_in,
  input  pix_t pixel_in,
  output logic out_valid,
  output act_t out_data,
  output logic out_last,
  input  logic out_ready,
  output logic overflow,
  input  logic clear_ovf
);

  localparam int unsigned RND_W = PIX_W + 1;
  localparam int unsigned CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [RND_W-1:0] ROUND   = RND_W'((32'd1 << SHIFT) >> 1);
  localparam logic [RND_W-1:0] ACT_MAX = RND_W'((32'd1 << ACT_W) - 32'd1);

  logic             r_s1_valid;
  logic [RND_W-1:0] r_s1_round;
  logic             r_s1_last;
  logic             r_s2_valid;
  act_beat_t        r_s2_beat;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_overflow;

  logic [RND_W-1:0] w_relu;
  logic             w_frame_last;
  logic [RND_W-1:0] w_q;
  act_t             w_sat;
  logic             w_fifo_valid;
  act_beat_t        w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;

  assign w_relu       = pixel_in[PIX_W-1] ? '0 : {1'b0, pixel_in};
  assign w_frame_last = (r_frame_cnt == CNT_W'(FRAME_PIXELS - 1));
  assign w_q          = r_s1_round >> SHIFT;
  assign w_sat        = (w_q > ACT_MAX) ? '1 : w_q[ACT_W-1:0];

  // S1: ReLU plus rounding offset, frame position tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_round  <= '0;
      r_s1_last   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_s1_valid <= valid_in;
      if (valid_in) begin
        r_s1_round  <= w_relu + ROUND;
        r_s1_last   <= w_frame_last;
        r_frame_cnt <= w_frame_last ? '0 : r_frame_cnt + CNT_W'(1);
      end
    end
  end

  // S2: shift and saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_beat  <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_beat <= '{data: w_sat, last: r_s1_last};
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(act_beat_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_s2_valid),
    .i_data  (r_s2_beat),
    .i_pop   (out_ready),
    .o_valid (w_fifo_valid),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A result is lost only when the FIFO is full and its head is not leaving.
  assign w_drop = r_s2_valid && w_full && !(out_ready && !w_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign out_valid = w_fifo_valid;
  assign out_data  = w_head.data;
  assign out_last  = w_head.last;
  assign overflow  = r_overflow;

endmodule
